// File: rtl/crcu_pkg.sv
// Shared definitions for the CRCU power sequencer: domain indices,
// sequencer state encoding and the domain-selection priority encoders.
package crcu_pkg;

   localparam int N_DOM = 8;
   localparam int DOM_W = $clog2(N_DOM);

   localparam int DOM_SPU       = 0;
   localparam int DOM_VPU       = 1;
   localparam int DOM_CPM       = 2;
   localparam int DOM_LD        = 3;
   localparam int DOM_WIDER_IOL = 4;
   localparam int DOM_TAP       = 5;
   localparam int DOM_DEBUG     = 6;
   localparam int DOM_VP_DEBUG  = 7;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_UP_CLK    = 4'd1,
      ST_UP_SETTLE = 4'd2,
      ST_UP_REL    = 4'd3,
      ST_UP_HOLD   = 4'd4,
      ST_DN_ASRT   = 4'd5,
      ST_DN_HOLD   = 4'd6,
      ST_DN_GATE   = 4'd7,
      ST_DN_SETTLE = 4'd8,
      ST_DONE      = 4'd9
   } seq_state_e;

   // Result of a priority search: index of the chosen bit and whether any bit was set.
   typedef struct packed {
      logic             valid;
      logic [DOM_W-1:0] idx;
   } dom_sel_t;

   // Lowest set bit wins (power-up order).
   function automatic dom_sel_t find_lowest(input logic [N_DOM-1:0] vec);
      dom_sel_t r;
      r.valid = 1'b0;
      r.idx   = '0;
      for (int i = N_DOM - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.valid = 1'b1;
            r.idx   = DOM_W'(i);
         end
      end
      return r;
   endfunction

   // Highest set bit wins (power-down order).
   function automatic dom_sel_t find_highest(input logic [N_DOM-1:0] vec);
      dom_sel_t r;
      r.valid = 1'b0;
      r.idx   = '0;
      for (int i = 0; i < N_DOM; i++) begin
         if (vec[i]) begin
            r.valid = 1'b1;
            r.idx   = DOM_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crcu_wait_cnt.sv
// Loadable saturating down-counter used for both clock-settle and reset-hold waits.
module crcu_wait_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             PCLK,
   input  logic             PRESETN,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Clear beats load beats decrement; decrement stops at zero instead of wrapping.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/crcu_pwr_sequencer.sv
// CRCU power sequencer: walks one domain at a time through clock-enable,
// settle wait, reset release and hold wait (power-down is the mirror),
// driving the per-domain clock gates and active-low resets.
module crcu_pwr_sequencer #(
   parameter int N_DOM = crcu_pkg::N_DOM,
   parameter int CNT_W = 8
) (
   input  logic                     PCLK,
   input  logic                     PRESETN,
   input  logic [N_DOM-1:0]         dom_req,
   input  logic [CNT_W-1:0]         settle_cycles,
   input  logic [CNT_W-1:0]         hold_cycles,
   input  logic                     force_rst,
   output logic [N_DOM-1:0]         clk_en,
   output logic [N_DOM-1:0]         rst_n,
   output logic [N_DOM-1:0]         dom_on,
   output logic                     busy,
   output logic                     seq_done,
   output logic [$clog2(N_DOM)-1:0] cur_dom,
   output logic [3:0]               dbg_state
);
   import crcu_pkg::*;

   seq_state_e                 state_q, state_d;
   logic [N_DOM-1:0]           mism;
   dom_sel_t                   up_sel, dn_sel;
   logic [CNT_W-1:0]           settle_l, hold_l;
   logic                       dir_up;
   logic                       take, take_up;
   logic [$clog2(N_DOM)-1:0]   take_idx;
   logic                       set_clk, clr_clk, set_rst, clr_rst, fin;
   logic                       cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]           cnt_val;

   // Domains whose requested state differs from their completed state.
   assign mism   = dom_req ^ dom_on;
   assign dn_sel = find_highest(mism & dom_on);
   assign up_sel = find_lowest(mism & dom_req);

   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

   crcu_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
      .PCLK     (PCLK),
      .PRESETN  (PRESETN),
      .clr      (force_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register; a soft reset parks the sequencer in IDLE.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q <= ST_IDLE;
      end else if (force_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle action decode; power-down is chosen before power-up.
   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      take_up  = 1'b0;
      take_idx = '0;
      set_clk  = 1'b0;
      clr_clk  = 1'b0;
      set_rst  = 1'b0;
      clr_rst  = 1'b0;
      fin      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (dn_sel.valid) begin
               take     = 1'b1;
               take_idx = dn_sel.idx;
               state_d  = ST_DN_ASRT;
            end else if (up_sel.valid) begin
               take     = 1'b1;
               take_up  = 1'b1;
               take_idx = up_sel.idx;
               state_d  = ST_UP_CLK;
            end
         end
         ST_UP_CLK: begin
            set_clk  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = settle_l;
            state_d  = ST_UP_SETTLE;
         end
         ST_UP_SETTLE: begin
            if (cnt_zero) state_d = ST_UP_REL;
            else          cnt_dec = 1'b1;
         end
         ST_UP_REL: begin
            set_rst  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = hold_l;
            state_d  = ST_UP_HOLD;
         end
         ST_UP_HOLD: begin
            if (cnt_zero) state_d = ST_DONE;
            else          cnt_dec = 1'b1;
         end
         ST_DN_ASRT: begin
            clr_rst  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = hold_l;
            state_d  = ST_DN_HOLD;
         end
         ST_DN_HOLD: begin
            if (cnt_zero) state_d = ST_DN_GATE;
            else          cnt_dec = 1'b1;
         end
         ST_DN_GATE: begin
            clr_clk  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = settle_l;
            state_d  = ST_DN_SETTLE;
         end
         ST_DN_SETTLE: begin
            if (cnt_zero) state_d = ST_DONE;
            else          cnt_dec = 1'b1;
         end
         ST_DONE: begin
            fin     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-domain outputs and the transition context latched at selection time.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         clk_en   <= '0;
         rst_n    <= '0;
         dom_on   <= '0;
         seq_done <= 1'b0;
         cur_dom  <= '0;
         dir_up   <= 1'b0;
         settle_l <= '0;
         hold_l   <= '0;
      end else if (force_rst) begin
         // Clock gates are left as they are so running clocks do not glitch.
         rst_n    <= '0;
         dom_on   <= '0;
         seq_done <= 1'b0;
      end else begin
         seq_done <= fin;
         if (take) begin
            cur_dom  <= take_idx;
            dir_up   <= take_up;
            settle_l <= settle_cycles;
            hold_l   <= hold_cycles;
         end
         if (set_clk) clk_en[cur_dom] <= 1'b1;
         if (clr_clk) clk_en[cur_dom] <= 1'b0;
         if (set_rst) rst_n[cur_dom]  <= 1'b1;
         if (clr_rst) rst_n[cur_dom]  <= 1'b0;
         if (fin)     dom_on[cur_dom] <= dir_up;
      end
   end

endmodule

// File: tb/tb_crcu_pwr_sequencer.sv
// Directed bench for the CRCU power sequencer.
module tb_crcu_pwr_sequencer;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_UP_CLK     = 4'd1;
  localparam logic [3:0] S_UP_SETTLE  = 4'd2;
  localparam logic [3:0] S_UP_HOLD    = 4'd4;
  localparam logic [3:0] S_DN_SETTLE  = 4'd8;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic [7:0] dom_req;
  logic [7:0] settle_cycles;
  logic [7:0] hold_cycles;
  logic       force_rst;
  logic [7:0] clk_en;
  logic [7:0] rst_n;
  logic [7:0] dom_on;
  logic       busy;
  logic       seq_done;
  logic [2:0] cur_dom;
  logic [3:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // clock/reset block
  always #5 PCLK = ~PCLK;

  crcu_pwr_sequencer #(.N_DOM(8), .CNT_W(8)) dut (
    .PCLK          (PCLK),
    .PRESETN       (PRESETN),
    .dom_req       (dom_req),
    .settle_cycles (settle_cycles),
    .hold_cycles   (hold_cycles),
    .force_rst     (force_rst),
    .clk_en        (clk_en),
    .rst_n         (rst_n),
    .dom_on        (dom_on),
    .busy          (busy),
    .seq_done      (seq_done),
    .cur_dom       (cur_dom),
    .dbg_state     (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESETN = 1'b0;
    dom_req = 8'h00;
    settle_cycles = 8'd0;
    hold_cycles = 8'd0;
    force_rst = 1'b0;
    repeat (2) tick();
    PRESETN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    dom_req = 8'h00;
    settle_cycles = 8'd0;
    hold_cycles = 8'd0;
    force_rst = 1'b0;
    repeat (3) tick();
    n_vec++; if (clk_en !== 8'h00) begin n_err++; $display("FAIL reset_clk_en: got %h want %h", clk_en, 8'h00); end
    n_vec++; if (rst_n !== 8'h00) begin n_err++; $display("FAIL reset_rst_n: got %h want %h", rst_n, 8'h00); end
    n_vec++; if (dom_on !== 8'h00) begin n_err++; $display("FAIL reset_dom_on: got %h want %h", dom_on, 8'h00); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (seq_done !== 1'b0) begin n_err++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    n_vec++; if (cur_dom !== 3'd0) begin n_err++; $display("FAIL reset_cur_dom: got %0d want 0", cur_dom); end
    n_vec++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    PRESETN = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got busy %b want 0", busy); end
  endtask

  task automatic test_power_up();
    int t_clk, t_rst, t_on, t_done, n_done;
    bit busy_ok;
    t_clk = -1; t_rst = -1; t_on = -1; t_done = -1; n_done = 0; busy_ok = 1'b1;
    settle_cycles = 8'd3;
    hold_cycles = 8'd2;
    dom_req = 8'h01;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (t_clk < 0 && clk_en[0]) t_clk = c;
      if (t_rst < 0 && rst_n[0]) t_rst = c;
      if (t_on < 0 && dom_on[0]) t_on = c;
      if (seq_done) begin n_done++; if (t_done < 0) t_done = c; end
      if (t_clk >= 0 && t_on < 0 && busy !== 1'b1) busy_ok = 1'b0;
    end
    n_vec++; if (t_clk !== 2) begin n_err++; $display("FAIL up_clk_latency: got %0d want 2", t_clk); end
    n_vec++; if (t_rst - t_clk !== 5) begin n_err++; $display("FAIL up_clk_to_rst: got %0d want 5", t_rst - t_clk); end
    n_vec++; if (t_on - t_rst !== 4) begin n_err++; $display("FAIL up_rst_to_on: got %0d want 4", t_on - t_rst); end
    n_vec++; if (t_done !== 11) begin n_err++; $display("FAIL up_seq_done_cycle: got %0d want 11", t_done); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL up_seq_done_count: got %0d want 1", n_done); end
    n_vec++; if (busy_ok !== 1'b1) begin n_err++; $display("FAIL up_busy_held: got %b want 1", busy_ok); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL up_busy_end: got %b want 0", busy); end
    n_vec++; if (clk_en !== 8'h01) begin n_err++; $display("FAIL up_clk_en: got %h want 01", clk_en); end
    n_vec++; if (rst_n !== 8'h01) begin n_err++; $display("FAIL up_rst_n: got %h want 01", rst_n); end
    n_vec++; if (dom_on !== 8'h01) begin n_err++; $display("FAIL up_dom_on: got %h want 01", dom_on); end
  endtask

  task automatic test_back_to_back();
    int t_on0, t_clk7, cd_first, cd_at7, n_done;
    do_reset();
    t_on0 = -1; t_clk7 = -1; cd_first = -1; cd_at7 = -1; n_done = 0;
    settle_cycles = 8'd1;
    hold_cycles = 8'd1;
    dom_req = 8'h81;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (cd_first < 0 && busy) cd_first = int'(cur_dom);
      if (t_on0 < 0 && dom_on[0]) t_on0 = c;
      if (t_clk7 < 0 && clk_en[7]) begin t_clk7 = c; cd_at7 = int'(cur_dom); end
      if (seq_done) n_done++;
    end
    n_vec++; if (t_on0 !== 8) begin n_err++; $display("FAIL b2b_dom0_done: got %0d want 8", t_on0); end
    n_vec++; if (t_clk7 - t_on0 !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", t_clk7 - t_on0); end
    n_vec++; if (cd_first !== 0) begin n_err++; $display("FAIL b2b_cur_dom_first: got %0d want 0", cd_first); end
    n_vec++; if (cd_at7 !== 7) begin n_err++; $display("FAIL b2b_cur_dom_second: got %0d want 7", cd_at7); end
    n_vec++; if (n_done !== 2) begin n_err++; $display("FAIL b2b_seq_done_count: got %0d want 2", n_done); end
    n_vec++; if (dom_on !== 8'h81) begin n_err++; $display("FAIL b2b_dom_on: got %h want 81", dom_on); end
  endtask

  task automatic test_power_down();
    int t_rf[8], t_cf[8], t_of[8];
    logic [7:0] p_rst, p_clk, p_on;
    logic [2:0] exp_q[$];
    int obs_q[$];
    int got;
    settle_cycles = 8'd0;
    hold_cycles = 8'd0;
    dom_req = 8'hFF;
    repeat (60) tick();
    n_vec++; if (dom_on !== 8'hFF) begin n_err++; $display("FAIL dn_all_on: got %h want ff", dom_on); end
    for (int i = 0; i < 8; i++) begin t_rf[i] = -1; t_cf[i] = -1; t_of[i] = -1; end
    for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
    p_rst = rst_n; p_clk = clk_en; p_on = dom_on;
    dom_req = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        if (p_rst[i] && !rst_n[i]) begin t_rf[i] = c; obs_q.push_back(i); end
        if (p_clk[i] && !clk_en[i]) t_cf[i] = c;
        if (p_on[i] && !dom_on[i]) t_of[i] = c;
      end
      p_rst = rst_n; p_clk = clk_en; p_on = dom_on;
    end
    while (exp_q.size() > 0) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_vec++;
      if (got !== int'(exp_q[0])) begin n_err++; $display("FAIL dn_order: got %0d want %0d", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (t_rf[i] < 0 || t_cf[i] - t_rf[i] !== 2) begin n_err++; $display("FAIL dn_rst_to_gate dom %0d: got %0d want 2", i, t_cf[i] - t_rf[i]); end
      n_vec++; if (t_cf[i] < 0 || t_of[i] - t_cf[i] !== 2) begin n_err++; $display("FAIL dn_gate_to_off dom %0d: got %0d want 2", i, t_of[i] - t_cf[i]); end
    end
    n_vec++; if ({clk_en, rst_n, dom_on} !== 24'h0) begin n_err++; $display("FAIL dn_all_off: got %h want 000000", {clk_en, rst_n, dom_on}); end
  endtask

  task automatic test_latch_mid();
    int t_cr, t_rr, t_or, t_rf, t_cf, t_of;
    bit changed;
    logic p_clk, p_rst, p_on;
    t_cr = -1; t_rr = -1; t_or = -1; t_rf = -1; t_cf = -1; t_of = -1; changed = 1'b0;
    p_clk = clk_en[2]; p_rst = rst_n[2]; p_on = dom_on[2];
    settle_cycles = 8'd2;
    hold_cycles = 8'd1;
    dom_req = 8'h07;
    for (int c = 1; c <= 90; c++) begin
      tick();
      if (!p_clk && clk_en[2]) t_cr = c;
      if (!p_rst && rst_n[2]) t_rr = c;
      if (!p_on && dom_on[2]) t_or = c;
      if (p_rst && !rst_n[2]) t_rf = c;
      if (p_clk && !clk_en[2]) t_cf = c;
      if (p_on && !dom_on[2]) t_of = c;
      p_clk = clk_en[2]; p_rst = rst_n[2]; p_on = dom_on[2];
      if (!changed && cur_dom == 3'd2 && dbg_state == S_UP_SETTLE) begin
        settle_cycles = 8'd10;
        dom_req = 8'h03;
        changed = 1'b1;
      end
    end
    n_vec++; if (changed !== 1'b1) begin n_err++; $display("FAIL mid_trigger: got %b want 1", changed); end
    n_vec++; if (t_cr < 0 || t_rr - t_cr !== 4) begin n_err++; $display("FAIL mid_latched_settle: got %0d want 4", t_rr - t_cr); end
    n_vec++; if (t_rr < 0 || t_or - t_rr !== 3) begin n_err++; $display("FAIL mid_latched_hold: got %0d want 3", t_or - t_rr); end
    n_vec++; if (t_or < 0 || t_rf - t_or !== 2) begin n_err++; $display("FAIL mid_reverse_start: got %0d want 2", t_rf - t_or); end
    n_vec++; if (t_rf < 0 || t_cf - t_rf !== 3) begin n_err++; $display("FAIL mid_dn_hold: got %0d want 3", t_cf - t_rf); end
    n_vec++; if (t_cf < 0 || t_of - t_cf !== 12) begin n_err++; $display("FAIL mid_dn_new_settle: got %0d want 12", t_of - t_cf); end
    n_vec++; if (dom_on !== 8'h03) begin n_err++; $display("FAIL mid_dom_on: got %h want 03", dom_on); end
    n_vec++; if (clk_en !== 8'h03) begin n_err++; $display("FAIL mid_clk_en: got %h want 03", clk_en); end
  endtask

  task automatic test_force_rst();
    bit found;
    int bad_clk, got;
    logic [7:0] p_on, rise;
    logic [2:0] exp_q[$];
    int obs_q[$];
    found = 1'b0; bad_clk = 0;
    settle_cycles = 8'd1;
    hold_cycles = 8'd3;
    dom_req = 8'h0F;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (cur_dom == 3'd3 && dbg_state == S_UP_HOLD) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL frc_reach_up_hold: got %b want 1", found); end
    force_rst = 1'b1;
    tick();
    n_vec++; if (rst_n !== 8'h00) begin n_err++; $display("FAIL frc_rst_n: got %h want 00", rst_n); end
    n_vec++; if (dom_on !== 8'h00) begin n_err++; $display("FAIL frc_dom_on: got %h want 00", dom_on); end
    n_vec++; if (clk_en !== 8'h0F) begin n_err++; $display("FAIL frc_clk_en_kept: got %h want 0f", clk_en); end
    n_vec++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL frc_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_vec++; if (seq_done !== 1'b0) begin n_err++; $display("FAIL frc_seq_done: got %b want 0", seq_done); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frc_held_busy: got %b want 0", busy); end
    end
    force_rst = 1'b0;
    tick();
    n_vec++; if (dbg_state !== S_UP_CLK) begin n_err++; $display("FAIL frc_repower_state: got %0d want %0d", dbg_state, S_UP_CLK); end
    n_vec++; if (cur_dom !== 3'd0) begin n_err++; $display("FAIL frc_repower_dom: got %0d want 0", cur_dom); end
    for (int i = 0; i < 4; i++) exp_q.push_back(3'(i));
    p_on = dom_on;
    for (int c = 1; c <= 60; c++) begin
      tick();
      rise = dom_on & ~p_on;
      for (int i = 0; i < 8; i++) if (rise[i]) obs_q.push_back(i);
      p_on = dom_on;
      if (clk_en !== 8'h0F) bad_clk++;
    end
    while (exp_q.size() > 0) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_vec++;
      if (got !== int'(exp_q[0])) begin n_err++; $display("FAIL frc_reseq_order: got %0d want %0d", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    n_vec++; if (bad_clk !== 0) begin n_err++; $display("FAIL frc_clk_en_stable: got %0d bad cycles want 0", bad_clk); end
    n_vec++; if (dom_on !== 8'h0F) begin n_err++; $display("FAIL frc_final_dom_on: got %h want 0f", dom_on); end
    n_vec++; if (rst_n !== 8'h0F) begin n_err++; $display("FAIL frc_final_rst_n: got %h want 0f", rst_n); end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    settle_cycles = 8'd5;
    hold_cycles = 8'd0;
    dom_req = 8'h07;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (dbg_state == S_DN_SETTLE) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1 || cur_dom !== 3'd3) begin n_err++; $display("FAIL arst_reach_dn_settle: got %b dom %0d want 1 dom 3", found, cur_dom); end
    #3;
    PRESETN = 1'b0;
    #1;
    n_vec++; if ({clk_en, rst_n, dom_on} !== 24'h0) begin n_err++; $display("FAIL arst_outputs: got %h want 000000", {clk_en, rst_n, dom_on}); end
    n_vec++; if ({busy, seq_done} !== 2'b00) begin n_err++; $display("FAIL arst_flags: got %b want 00", {busy, seq_done}); end
    n_vec++; if (cur_dom !== 3'd0) begin n_err++; $display("FAIL arst_cur_dom: got %0d want 0", cur_dom); end
    n_vec++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL arst_state: got %0d want %0d", dbg_state, S_IDLE); end
    tick();
    dom_req = 8'h00;
    PRESETN = 1'b1;
    tick();
    n_vec++; if (dbg_state !== S_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL arst_idle_after: got state %0d busy %b want 0 0", dbg_state, busy); end
  endtask

  task automatic test_max_settle();
    int t_clk, t_rst, t_on;
    do_reset();
    t_clk = -1; t_rst = -1; t_on = -1;
    settle_cycles = 8'd255;
    hold_cycles = 8'd0;
    dom_req = 8'h01;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (t_clk < 0 && clk_en[0]) t_clk = c;
      if (t_rst < 0 && rst_n[0]) t_rst = c;
      if (t_on < 0 && dom_on[0]) t_on = c;
    end
    n_vec++; if (t_clk < 0 || t_rst - t_clk !== 257) begin n_err++; $display("FAIL max_settle: got %0d want 257", t_rst - t_clk); end
    n_vec++; if (t_rst < 0 || t_on - t_rst !== 2) begin n_err++; $display("FAIL zero_hold: got %0d want 2", t_on - t_rst); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_back_to_back();
    test_power_down();
    test_latch_mid();
    test_force_rst();
    test_async_reset();
    test_max_settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
